// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A grant is held for a whole message (req_last) or until MAX_BURST bytes have gone out.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 ack_err
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] ONE       = NUM_REQ'(1);
    localparam logic [7:0]         BURST_MAX = 8'(MAX_BURST);
    localparam logic [CW-1:0]      ACK_LAST  = CW'(ACK_TIMEOUT - 1);
    localparam logic [IW-1:0]      IDX_LAST  = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t               r_state, w_state;
    logic [IW-1:0]        r_gidx, w_gidx;
    logic [NUM_REQ-1:0]   r_grant, w_grant;
    logic [IW-1:0]        r_rr_ptr, w_rr_ptr;
    logic [7:0]           r_burst_cnt, w_burst_cnt;
    logic                 r_last_q, w_last_q;
    logic [7:0]           r_tx_data, w_tx_data;
    logic [CW-1:0]        r_ack_cnt, w_ack_cnt;

    logic [IW-1:0]        w_pick;
    logic [IW-1:0]        w_cand;
    logic [IW-1:0]        w_gnext;
    logic                 w_sel_valid;
    logic [7:0]           w_sel_data;
    int                   v_idx;

    // Scan downward so the lowest offset from rr_ptr is the one that sticks.
    always_comb begin
        w_pick = '0;
        w_cand = '0;
        v_idx  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            v_idx = int'(r_rr_ptr) + k;
            if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
            w_cand = IW'(v_idx);
            if (req_valid[w_cand]) w_pick = w_cand;
        end
    end

    assign w_gnext     = (r_gidx == IDX_LAST) ? '0 : r_gidx + 1'b1;
    assign w_sel_valid = req_valid[r_gidx];
    assign w_sel_data  = req_data[{r_gidx, 3'b000} +: 8];

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gidx      <= '0;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
            r_last_q    <= 1'b0;
            r_tx_data   <= 8'h00;
            r_ack_cnt   <= '0;
        end else begin
            r_state     <= w_state;
            r_gidx      <= w_gidx;
            r_grant     <= w_grant;
            r_rr_ptr    <= w_rr_ptr;
            r_burst_cnt <= w_burst_cnt;
            r_last_q    <= w_last_q;
            r_tx_data   <= w_tx_data;
            r_ack_cnt   <= w_ack_cnt;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_gidx      = r_gidx;
        w_grant     = r_grant;
        w_rr_ptr    = r_rr_ptr;
        w_burst_cnt = r_burst_cnt;
        w_last_q    = r_last_q;
        w_tx_data   = r_tx_data;
        w_ack_cnt   = r_ack_cnt;
        req_ready   = '0;
        tx_start    = 1'b0;
        ack_err     = 1'b0;

        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_gidx      = w_pick;
                    w_grant     = ONE << w_pick;
                    w_burst_cnt = '0;
                    w_state     = SEND;
                end
            end
            SEND: begin
                if (!w_sel_valid) begin
                    w_grant  = '0;
                    w_rr_ptr = w_gnext;
                    w_state  = IDLE;
                end else if (!tx_busy) begin
                    req_ready   = ONE << r_gidx;
                    tx_start    = 1'b1;
                    w_tx_data   = w_sel_data;
                    w_last_q    = req_last[r_gidx];
                    w_burst_cnt = (r_burst_cnt == 8'hFF) ? r_burst_cnt : r_burst_cnt + 8'd1;
                    w_ack_cnt   = '0;
                    w_state     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    w_state = WAIT_DONE;
                end else if (r_ack_cnt == ACK_LAST) begin
                    ack_err = 1'b1;
                    if (r_last_q || r_burst_cnt == BURST_MAX) begin
                        w_grant  = '0;
                        w_rr_ptr = w_gnext;
                        w_state  = IDLE;
                    end else begin
                        w_state = SEND;
                    end
                end else begin
                    w_ack_cnt = r_ack_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_last_q || r_burst_cnt == BURST_MAX) begin
                        w_grant  = '0;
                        w_rr_ptr = w_gnext;
                        w_state  = IDLE;
                    end else begin
                        w_state = SEND;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    assign grant   = r_grant;
    assign tx_data = r_tx_data;
endmodule
